// File: rtl/dm_pkg.sv
// Shared types and helpers for the data-memory responder.
package dm_pkg;

   localparam int DM_WORD_W = 32;
   localparam int DM_BE_W   = 4;

   typedef enum logic [1:0] {
      DM_IDLE,
      DM_WAIT,
      DM_RESP
   } dm_state_e;

   // Replace only the enabled bytes of old_word with those of new_word.
   function automatic logic [DM_WORD_W-1:0] dm_merge(
      input logic [DM_WORD_W-1:0] old_word,
      input logic [DM_WORD_W-1:0] new_word,
      input logic [DM_BE_W-1:0]   be
   );
      logic [DM_WORD_W-1:0] res;
      res = old_word;
      for (int i = 0; i < DM_BE_W; i++) begin
         if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/dm_storage.sv
// DEPTH x 32 word array: byte-masked synchronous write, combinational read,
// whole array cleared while rst_dm is high.
module dm_storage
   import dm_pkg::*;
#(
   parameter int DEPTH = 1024,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst_dm,
   input  logic                 wr_en,
   input  logic [IDX_W-1:0]     idx,
   input  logic [DM_WORD_W-1:0] wdata,
   input  logic [DM_BE_W-1:0]   be,
   output logic [DM_WORD_W-1:0] rd_data
);

   logic [DM_WORD_W-1:0] mem_q [DEPTH];
   logic [DM_WORD_W-1:0] wr_word_d;

   always_comb begin
      wr_word_d = dm_merge(mem_q[idx], wdata, be);
      rd_data   = mem_q[idx];
   end

   always_ff @(posedge clk) begin
      if (rst_dm) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (wr_en) begin
         mem_q[idx] <= wr_word_d;
      end
   end

endmodule

// File: rtl/dm_wait_responder.sv
// Data-memory responder with LATENCY wait states between request accept and response,
// one outstanding transaction, byte-enable stores and misaligned/out-of-range error flag.
module dm_wait_responder
   import dm_pkg::*;
#(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 2,
   parameter int ADDR_W  = 32
) (
   input  logic                 clk,
   input  logic                 rst_dm,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_we,
   input  logic [ADDR_W-1:0]    req_addr,
   input  logic [DM_WORD_W-1:0] req_wdata,
   input  logic [DM_BE_W-1:0]   req_be,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [DM_WORD_W-1:0] resp_rdata,
   output logic                 resp_err,
   output logic                 busy
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [ADDR_W-1:0] ADDR_LIM = ADDR_W'(4 * DEPTH);

   dm_state_e            state_q, state_d;
   logic [3:0]           cnt_q, cnt_d;
   logic                 we_q, we_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [DM_WORD_W-1:0] wdata_q, wdata_d;
   logic [DM_BE_W-1:0]   be_q, be_d;
   logic [DM_WORD_W-1:0] rdata_q, rdata_d;
   logic                 err_q, err_d;

   logic                 in_idle, accept, commit;
   logic                 cur_we, cur_err, mem_wr;
   logic [ADDR_W-1:0]    cur_addr;
   logic [DM_WORD_W-1:0] cur_wdata, rd_word;
   logic [DM_BE_W-1:0]   cur_be;

   assign in_idle = (state_q == DM_IDLE);
   assign accept  = req_valid && in_idle;

   // Commit point is the cycle entering RESP; with zero latency that is the accept
   // cycle itself, so the live request fields are used instead of the latched ones.
   assign commit = (in_idle && accept && (LATENCY == 0)) ||
                   ((state_q == DM_WAIT) && (cnt_q == 4'd0));

   always_comb begin
      cur_we    = in_idle ? req_we    : we_q;
      cur_addr  = in_idle ? req_addr  : addr_q;
      cur_wdata = in_idle ? req_wdata : wdata_q;
      cur_be    = in_idle ? req_be    : be_q;
      cur_err   = (cur_addr[1:0] != 2'b00) || (cur_addr >= ADDR_LIM);
      mem_wr    = commit && cur_we && !cur_err;
   end

   dm_storage #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_storage (
      .clk     (clk),
      .rst_dm  (rst_dm),
      .wr_en   (mem_wr),
      .idx     (cur_addr[IDX_W+1:2]),
      .wdata   (cur_wdata),
      .be      (cur_be),
      .rd_data (rd_word)
   );

   always_ff @(posedge clk) begin
      if (rst_dm) state_q <= DM_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         DM_IDLE: if (accept) state_d = (LATENCY == 0) ? DM_RESP : DM_WAIT;
         DM_WAIT: if (cnt_q == 4'd0) state_d = DM_RESP;
         DM_RESP: if (resp_ready) state_d = DM_IDLE;
         default: state_d = DM_IDLE;
      endcase
   end

   always_comb begin
      req_ready  = in_idle;
      resp_valid = (state_q == DM_RESP);
      busy       = !in_idle;
      resp_rdata = rdata_q;
      resp_err   = err_q;
   end

   always_comb begin
      cnt_d   = cnt_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      if (accept) begin
         we_d    = req_we;
         addr_d  = req_addr;
         wdata_d = req_wdata;
         be_d    = req_be;
         cnt_d   = 4'(LATENCY - 1);
      end else if ((state_q == DM_WAIT) && (cnt_q != 4'd0)) begin
         cnt_d = cnt_q - 4'd1;
      end
      if (commit) begin
         err_d   = cur_err;
         rdata_d = (cur_err || cur_we) ? '0 : rd_word;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_dm) begin
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_dm_wait_responder.sv
// Directed bench: LATENCY=2 instance for the main scenarios, LATENCY=0 instance for the short path.
module tb_dm_wait_responder;

   logic        clk = 1'b0;
   logic        rst_dm;
   logic        sel;
   logic        req_valid, req_we, resp_ready;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_be;

   logic        rr0, rv0, re0, bz0, rr1, rv1, re1, bz1;
   logic [31:0] rd0, rd1;
   logic        o_req_ready, o_resp_valid, o_resp_err, o_busy;
   logic [31:0] o_resp_rdata;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dm_wait_responder #(.DEPTH(1024), .LATENCY(2), .ADDR_W(32)) u_dut0 (
      .clk(clk), .rst_dm(rst_dm),
      .req_valid(req_valid && !sel), .req_ready(rr0), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .resp_valid(rv0), .resp_ready(resp_ready && !sel),
      .resp_rdata(rd0), .resp_err(re0), .busy(bz0)
   );

   dm_wait_responder #(.DEPTH(1024), .LATENCY(0), .ADDR_W(32)) u_dut1 (
      .clk(clk), .rst_dm(rst_dm),
      .req_valid(req_valid && sel), .req_ready(rr1), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .resp_valid(rv1), .resp_ready(resp_ready && sel),
      .resp_rdata(rd1), .resp_err(re1), .busy(bz1)
   );

   assign o_req_ready  = sel ? rr1 : rr0;
   assign o_resp_valid = sel ? rv1 : rv0;
   assign o_resp_rdata = sel ? rd1 : rd0;
   assign o_resp_err   = sel ? re1 : re0;
   assign o_busy       = sel ? bz1 : bz0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_resp(output int n);
      n = 0;
      while (!o_resp_valid && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) check("resp_timeout", 32'd1, 32'd0);
   endtask

   // One full transaction; lat is cycles from accept to resp_valid high.
   task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, output int lat,
                         output logic [31:0] rdata, output logic err);
      int n;
      req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
      req_valid = 1'b1;
      n = 0;
      while (!o_req_ready && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) check("accept_timeout", 32'd1, 32'd0);
      tick();
      req_valid = 1'b0;
      wait_resp(n);
      lat   = n + 1;
      rdata = o_resp_rdata;
      err   = o_resp_err;
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
   endtask

   initial begin
      int          lat, n, seen;
      logic [31:0] rd;
      logic        er;

      sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; resp_ready = 1'b0;
      req_addr = '0; req_wdata = '0; req_be = '0;
      rst_dm = 1'b1;
      tick(); tick();
      rst_dm = 1'b0;

      // Reset state and first load
      check("rst_req_ready", 32'(o_req_ready), 32'd1);
      check("rst_resp_valid", 32'(o_resp_valid), 32'd0);
      check("rst_busy", 32'(o_busy), 32'd0);
      check("rst_rdata", o_resp_rdata, 32'd0);
      do_req(1'b0, 32'h10, 32'h0, 4'hF, lat, rd, er);
      check("rst_load_rdata", rd, 32'd0);
      check("rst_load_err", 32'(er), 32'd0);

      // Full store, latency, read back
      do_req(1'b1, 32'h20, 32'hDEADBEEF, 4'hF, lat, rd, er);
      check("st_latency", 32'(lat), 32'd3);
      check("st_rdata", rd, 32'd0);
      check("st_err", 32'(er), 32'd0);
      do_req(1'b0, 32'h20, 32'h0, 4'h0, lat, rd, er);
      check("ld_rdata", rd, 32'hDEADBEEF);
      check("ld_err", 32'(er), 32'd0);

      // Byte enables, plus be=0 no-op
      do_req(1'b1, 32'h20, 32'h11223344, 4'b0101, lat, rd, er);
      do_req(1'b1, 32'h20, 32'h99999999, 4'b0000, lat, rd, er);
      do_req(1'b0, 32'h20, 32'h0, 4'h0, lat, rd, er);
      check("be_merge", rd, 32'hDE22BE44);

      // Errors
      do_req(1'b0, 32'h22, 32'h0, 4'hF, lat, rd, er);
      check("mis_err", 32'(er), 32'd1);
      check("mis_rdata", rd, 32'd0);
      do_req(1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, lat, rd, er);
      check("oor_err", 32'(er), 32'd1);
      do_req(1'b0, 32'h0, 32'h0, 4'hF, lat, rd, er);
      check("oor_word0", rd, 32'd0);
      check("oor_word0_err", 32'(er), 32'd0);
      do_req(1'b0, 32'hFFC, 32'h0, 4'hF, lat, rd, er);
      check("last_word_err", 32'(er), 32'd0);

      // Backpressure: response held 5 cycles, a second request waits
      req_we = 1'b0; req_addr = 32'h20; req_be = 4'hF; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      wait_resp(n);
      req_we = 1'b1; req_addr = 32'h24; req_wdata = 32'hCAFEF00D; req_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("bp_resp_valid", 32'(o_resp_valid), 32'd1);
         check("bp_rdata", o_resp_rdata, 32'hDE22BE44);
         check("bp_req_ready", 32'(o_req_ready), 32'd0);
         tick();
      end
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      check("bp_after_hs_ready", 32'(o_req_ready), 32'd1);
      check("bp_after_hs_valid", 32'(o_resp_valid), 32'd0);
      tick();
      req_valid = 1'b0;
      check("bp_second_busy", 32'(o_busy), 32'd1);
      wait_resp(n);
      check("bp_second_lat", 32'(n + 1), 32'd3);
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      do_req(1'b0, 32'h24, 32'h0, 4'hF, lat, rd, er);
      check("bp_second_data", rd, 32'hCAFEF00D);

      // Reset during WAIT aborts the store
      req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'h55; req_be = 4'hF; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      check("abort_busy", 32'(o_busy), 32'd1);
      rst_dm = 1'b1;
      tick(); tick();
      rst_dm = 1'b0;
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         if (o_resp_valid) seen++;
         tick();
      end
      check("abort_no_resp", 32'(seen), 32'd0);
      do_req(1'b0, 32'h40, 32'h0, 4'hF, lat, rd, er);
      check("abort_load", rd, 32'd0);
      do_req(1'b0, 32'h20, 32'h0, 4'hF, lat, rd, er);
      check("abort_mem_cleared", rd, 32'd0);

      // Zero-latency instance
      sel = 1'b1;
      do_req(1'b1, 32'h20, 32'hDEADBEEF, 4'hF, lat, rd, er);
      check("l0_st_latency", 32'(lat), 32'd1);
      do_req(1'b0, 32'h20, 32'h0, 4'hF, lat, rd, er);
      check("l0_ld_latency", 32'(lat), 32'd1);
      check("l0_ld_rdata", rd, 32'hDEADBEEF);
      do_req(1'b0, 32'h21, 32'h0, 4'hF, lat, rd, er);
      check("l0_mis_err", 32'(er), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
